// File: rtl/oldland_bus_arbiter.sv
// oldland_bus_arbiter
//   Shares one single-beat external memory bus between the instruction fetch
//   port (i_*) and the memory-stage data port (d_*). One owner at a time,
//   round-robin on contention. Ack, error and read data go back only to the
//   owner.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     i_addr/i_access       fetch request (read-only, full word)
//     i_data/i_ack/i_error  fetch response (ack and error are 1-cycle pulses)
//     d_addr/d_bytesel/d_wr_en/d_wr_val/d_access  data request
//     d_data/d_ack/d_error  data response
//     b_addr/b_bytesel/b_wr_en/b_wr_val/b_access  bus request (muxed)
//     b_data/b_ack/b_error  bus response
//
//   Build option: define BUS_TIMEOUT_EN to abort a transaction with an
//   error after TIMEOUT_CYCLES bus cycles that see no ack and no error.
module oldland_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_access,
  output logic [31:0] i_data,
  output logic        i_ack,
  output logic        i_error,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  input  logic        d_access,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,
  output logic [31:0] b_addr,
  output logic [3:0]  b_bytesel,
  output logic        b_wr_en,
  output logic [31:0] b_wr_val,
  output logic        b_access,
  input  logic [31:0] b_data,
  input  logic        b_ack,
  input  logic        b_error
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  // last_grant encoding: 0 = fetch, 1 = data
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   busy;
  logic   tmo;
  logic   done;
  logic   bus_err;

  assign busy = (state_q != IDLE);

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter value equals the number of BUSY cycles already elapsed in this
  // transaction, so the TIMEOUT_CYCLES-th BUSY cycle sees TIMEOUT_CYCLES-1.
  assign tmo = busy && !b_ack && !b_error &&
               (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    // Clearing in IDLE and on any completion covers every BUSY entry,
    // including back-to-back hand-over.
    if (!busy || done) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  // No watchdog: the bus is trusted to answer eventually. The term keeps the
  // parameter referenced in this build; it is never true for a legal value.
  assign tmo = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  assign done    = busy && (b_ack || b_error || tmo);
  // A real bus error wins over a simultaneous ack.
  assign bus_err = b_error || tmo;

  // Next state / grant
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (i_access && d_access) begin
          // Tie: serve whoever did not win last time.
          if (last_grant_q == GRANT_I) begin
            state_d      = D_BUSY;
            last_grant_d = GRANT_D;
          end else begin
            state_d      = I_BUSY;
            last_grant_d = GRANT_I;
          end
        end else if (i_access) begin
          state_d      = I_BUSY;
          last_grant_d = GRANT_I;
        end else if (d_access) begin
          state_d      = D_BUSY;
          last_grant_d = GRANT_D;
        end
      end
      I_BUSY: begin
        // Completing port's own access is ignored here; it drops next cycle.
        if (done) begin
          if (d_access) begin
            state_d      = D_BUSY;
            last_grant_d = GRANT_D;
          end else begin
            state_d = IDLE;
          end
        end
      end
      D_BUSY: begin
        if (done) begin
          if (i_access) begin
            state_d      = I_BUSY;
            last_grant_d = GRANT_I;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Bus mux and response routing
  always_comb begin
    b_addr    = '0;
    b_bytesel = '0;
    b_wr_en   = 1'b0;
    b_wr_val  = '0;
    b_access  = busy;
    i_data    = '0;
    i_ack     = 1'b0;
    i_error   = 1'b0;
    d_data    = '0;
    d_ack     = 1'b0;
    d_error   = 1'b0;
    if (state_q == I_BUSY) begin
      b_addr    = i_addr;
      b_bytesel = 4'b1111;
      i_data    = b_data;
      i_ack     = b_ack && !bus_err;
      i_error   = bus_err;
    end else if (state_q == D_BUSY) begin
      b_addr    = d_addr;
      b_bytesel = d_bytesel;
      b_wr_en   = d_wr_en;
      b_wr_val  = d_wr_val;
      d_data    = b_data;
      d_ack     = b_ack && !bus_err;
      d_error   = bus_err;
    end
  end

endmodule

// File: tb/tb_oldland_bus_arbiter.sv
// Directed bench for oldland_bus_arbiter. Inputs change 1ns after the rising
// edge; outputs are sampled after a further settle delay.
module tb_oldland_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr;
  logic        i_access;
  logic [31:0] i_data;
  logic        i_ack, i_error;
  logic [31:0] d_addr;
  logic [3:0]  d_bytesel;
  logic        d_wr_en;
  logic [31:0] d_wr_val;
  logic        d_access;
  logic [31:0] d_data;
  logic        d_ack, d_error;
  logic [31:0] b_addr;
  logic [3:0]  b_bytesel;
  logic        b_wr_en;
  logic [31:0] b_wr_val;
  logic        b_access;
  logic [31:0] b_data;
  logic        b_ack, b_error;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  oldland_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_access(i_access), .i_data(i_data),
    .i_ack(i_ack), .i_error(i_error),
    .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_en(d_wr_en),
    .d_wr_val(d_wr_val), .d_access(d_access), .d_data(d_data),
    .d_ack(d_ack), .d_error(d_error),
    .b_addr(b_addr), .b_bytesel(b_bytesel), .b_wr_en(b_wr_en),
    .b_wr_val(b_wr_val), .b_access(b_access), .b_data(b_data),
    .b_ack(b_ack), .b_error(b_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // advance one clock; return 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; i_addr = '0; i_access = 0; d_addr = '0; d_bytesel = '0;
    d_wr_en = 0; d_wr_val = '0; d_access = 0; b_data = '0; b_ack = 0; b_error = 0;
    tick(); tick();
    chk("rst_b_access", {31'd0, b_access}, 0);
    chk("rst_b_addr", b_addr, 0);
    chk("rst_resp", {i_ack, i_error, d_ack, d_error}, 0);
    rst_n = 1'b1;
    tick();

    // bus ack while idle is ignored
    b_ack = 1; b_data = 32'h1234_5678; settle();
    chk("idle_ack_ignored", {i_ack, d_ack, b_access}, 0);
    b_ack = 0; tick();
    chk("idle_stays", {31'd0, b_access}, 0);

    // fetch only
    i_addr = 32'h100; i_access = 1; settle();
    chk("fetch_req_cycle_no_access", {31'd0, b_access}, 0);
    tick();
    chk("fetch_b_access", {31'd0, b_access}, 1);
    chk("fetch_b_addr", b_addr, 32'h100);
    chk("fetch_b_bytesel", {28'd0, b_bytesel}, 32'hF);
    chk("fetch_b_wr", {b_wr_en, b_wr_val[30:0]}, 0);
    tick(); tick();
    chk("fetch_wait_no_ack", {i_ack, d_ack}, 0);
    tick();
    b_ack = 1; b_data = 32'hDEAD_BEEF; settle();
    chk("fetch_i_ack", {31'd0, i_ack}, 1);
    chk("fetch_i_data", i_data, 32'hDEAD_BEEF);
    chk("fetch_d_quiet", {d_ack, d_error, i_error}, 0);
    chk("fetch_d_data_zero", d_data, 0);
    tick();
    b_ack = 0; i_access = 0; settle();
    chk("fetch_back_idle", {31'd0, b_access}, 0);
    chk("fetch_single_pulse", {i_ack}, 0);

    // data write
    d_addr = 32'h2000; d_bytesel = 4'b0100; d_wr_val = 32'h00AB_0000;
    d_wr_en = 1; d_access = 1;
    tick();
    chk("dwr_b_addr", b_addr, 32'h2000);
    chk("dwr_b_bytesel", {28'd0, b_bytesel}, 32'h4);
    chk("dwr_b_wr_en", {31'd0, b_wr_en}, 1);
    chk("dwr_b_wr_val", b_wr_val, 32'h00AB_0000);
    b_ack = 1; b_data = 32'h0; settle();
    chk("dwr_d_ack", {i_ack, d_ack}, 1);
    tick();
    b_ack = 0; d_access = 0; d_wr_en = 0; settle();
    chk("dwr_back_idle", {b_access, d_ack}, 0);

    // reset mid-transaction
    i_addr = 32'h300; i_access = 1;
    tick();
    chk("mid_rst_busy", {31'd0, b_access}, 1);
    b_ack = 1; b_data = 32'hFFFF_FFFF;
    rst_n = 0; settle();
    chk("mid_rst_b_access", {31'd0, b_access}, 0);
    chk("mid_rst_b_addr", b_addr, 0);
    chk("mid_rst_resp", {i_ack, i_error, d_ack, d_error}, 0);
    chk("mid_rst_i_data", i_data, 0);
    b_ack = 0; i_access = 0;
    tick();
    rst_n = 1;
    tick();

    // tie after reset: D first, then I back-to-back
    i_addr = 32'h400; d_addr = 32'h500; d_bytesel = 4'hF;
    i_access = 1; d_access = 1;
    tick();
    chk("tie_first_d", b_addr, 32'h500);
    b_ack = 1; settle();
    chk("tie_d_ack", {i_ack, d_ack}, 1);
    tick();
    d_access = 0; b_ack = 0; settle();
    chk("tie_no_gap", {31'd0, b_access}, 1);
    chk("tie_then_i", b_addr, 32'h400);
    b_ack = 1; settle();
    chk("tie_i_ack", {i_ack, d_ack}, 2);
    tick();
    i_access = 0; b_ack = 0; settle();
    chk("tie_idle", {31'd0, b_access}, 0);

    // continuous contention: last grant was I, so D,I,D,I
    i_access = 1; d_access = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_addr;
      exp_addr = (k % 2 == 0) ? 32'h500 : 32'h400;
      chk($sformatf("rr_owner_%0d", k), b_addr, exp_addr);
      chk($sformatf("rr_access_%0d", k), {31'd0, b_access}, 1);
      if (k == 3) d_access = 0;
      b_ack = 1; settle();
      chk($sformatf("rr_ack_%0d", k), {30'd0, i_ack, d_ack}, (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      b_ack = 0;
    end
    i_access = 0; settle();
    chk("rr_idle", {31'd0, b_access}, 0);

    // ack and error together: error wins
    i_access = 1;
    tick();
    b_ack = 1; b_error = 1; settle();
    chk("err_wins", {29'd0, i_error, i_ack, d_error}, 32'd4);
    tick();
    b_ack = 0; b_error = 0; i_access = 0; settle();
    chk("err_idle", {b_access, i_error}, 0);

`ifdef BUS_TIMEOUT_EN
    d_access = 1;
    tick();
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("tmo_wait_%0d", c), {b_access, d_error}, 2);
      tick();
    end
    chk("tmo_d_error", {b_access, d_error, d_ack}, 32'd6);
    tick();
    d_access = 0; settle();
    chk("tmo_drop", {b_access, d_error}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/oldland_bus_arbiter.md
Name: oldland_bus_arbiter

Overview:
- Shares one external memory bus between the instruction fetch port and the data port driven by the memory stage.
- Each requester issues a single-beat access/ack/error transaction. The arbiter grants one owner at a time and muxes address, byte selects and write data onto the bus.
- Routes ack/error/read data back only to the owner.
- Round-robin on contention so neither fetch nor load/store starves. Sits between the CPU core and the bus/SDRAM/peripheral interconnect.

Parameters:
- TIMEOUT_CYCLES, 256: bus cycles allowed per transaction before abort. Used only with BUS_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_addr  input  32  fetch word address
- i_access  input  1  fetch request; held until i_ack/i_error
- i_data  output  32  fetch read data; valid in i_ack cycle
- i_ack  output  1  fetch complete (1-cycle pulse)
- i_error  output  1  fetch bus error (1-cycle pulse)
- d_addr  input  32  data word address
- d_bytesel  input  4  data byte enables
- d_wr_en  input  1  data write (1) / read (0)
- d_wr_val  input  32  data write value
- d_access  input  1  data request; held until d_ack/d_error
- d_data  output  32  data read value; valid in d_ack cycle
- d_ack  output  1  data complete (1-cycle pulse)
- d_error  output  1  data bus error (1-cycle pulse)
- b_addr  output  32  bus address
- b_bytesel  output  4  bus byte enables
- b_wr_en  output  1  bus write enable
- b_wr_val  output  32  bus write data
- b_access  output  1  bus transaction active
- b_data  input  32  bus read data
- b_ack  input  1  bus completion
- b_error  input  1  bus error

Behaviour:
- States: IDLE, I_BUSY, D_BUSY. There is also a 1-bit last_grant register (I/D).
- Reset (async, rst_n low):
  - state=IDLE, last_grant=I.
  - All outputs 0; b_addr/b_wr_val/b_bytesel/b_wr_en 0.
  - Reset mid-transaction abandons the transaction with no ack/error to either side.
- Fetch bus outputs:
  - i_bytesel is implicitly 4'b1111 and i_wr_en 0.
  - In I_BUSY, b_addr=i_addr, b_bytesel=4'b1111, b_wr_en=0, b_wr_val=0.
- Data bus outputs:
  - In D_BUSY, b_* = d_* combinationally.
  - In IDLE, all b_* are 0 and b_access=0.
- b_access = (state != IDLE).
- Grant from IDLE:
  - Only i_access → I_BUSY next cycle.
  - Only d_access → D_BUSY.
  - Both → the port not equal to last_grant. After reset a tie goes to D.
  - last_grant updates on entry to a BUSY state.
- Latency: a request sampled high in IDLE at cycle N gives b_access high at N+1. Minimum transaction is 2 cycles (request, then ack in BUSY).
- Completion in X_BUSY:
  - b_ack=1, b_error=0 → pulse x_ack for that cycle, with x_data=b_data.
  - b_error=1 → pulse x_error. x_ack is suppressed even if b_ack is also 1.
  - Non-owner ack/error stay 0; non-owner data is 0.
- Next state after completion:
  - If the other port's access is high → go directly to its BUSY (back-to-back, no idle cycle).
  - Otherwise → IDLE.
  - The completing port's access is ignored in the completion cycle (it drops next cycle).
- Owner drops access before ack: illegal. The arbiter keeps the transaction open until b_ack/b_error.
- b_ack/b_error in IDLE: ignored.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to any BUSY state and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without b_ack/b_error, the owner gets a 1-cycle x_error, b_access drops, and the state arbitrates as for a normal completion.
  - A real b_ack/b_error on the same cycle as the timeout takes precedence.
- Undefined: no counter; the arbiter waits indefinitely for b_ack/b_error.

Test Plan:
- Fetch only: i_addr=0x100 held, bus acks 3 cycles after b_access with b_data=0xDEADBEEF → b_addr=0x100, b_bytesel=4'hF, b_wr_en=0; one i_ack pulse with i_data=0xDEADBEEF; d_ack stays 0.
- Data write: d_addr=0x2000, d_bytesel=4'b0100, d_wr_val=0x00AB0000, d_wr_en=1 → bus sees identical values; one d_ack pulse; state returns to IDLE.
- Tie after reset: both request in the same cycle → D served first, then I back-to-back (b_access never drops), each acked once.
- Continuous contention over 4 transactions → grants alternate D,I,D,I.
- b_ack and b_error both high during I_BUSY → i_error=1, i_ack=0.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, no bus ack → d_error pulses after 8 BUSY cycles and b_access drops. Separately, assert rst_n low mid-transaction → all outputs 0 immediately.
